// File: rtl/mic1_pkg.sv
// Shared MIC-1 datapath definitions: shift op encodings and the
// shift_sequencer state type.
package mic1_pkg;

    typedef logic [1:0] sh_op_t;

    localparam sh_op_t SH_SLL = 2'b00;
    localparam sh_op_t SH_SRL = 2'b01;
    localparam sh_op_t SH_SRA = 2'b10;
    localparam sh_op_t SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shseq_state_t;

endpackage

// File: rtl/shift_step.sv
// Purely combinational single-bit-position shift/rotate step.
// Also usable by the fixed single-cycle shifter.
module shift_step
    import mic1_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  sh_op_t                op,
    input  logic [DATA_WIDTH-1:0] acc,
    output logic [DATA_WIDTH-1:0] acc_next
);

    always_comb begin
        acc_next = acc;
        unique case (op)
            SH_SLL: acc_next = {acc[DATA_WIDTH-2:0], 1'b0};
            SH_SRL: acc_next = {1'b0, acc[DATA_WIDTH-1:1]};
            SH_SRA: acc_next = {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
            SH_ROR: acc_next = {acc[0], acc[DATA_WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable-amount shifter: one bit position per clock,
// start/busy/done handshake, registered result.
module shift_sequencer
    import mic1_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [DATA_WIDTH-1:0]  data,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  dataOut
);

    shseq_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    sh_op_t                 op_q, op_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0]  acc_step;

    shift_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift_step (
        .op       (op_q),
        .acc      (acc_q),
        .acc_next (acc_step)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? SHIFT : IDLE;
            SHIFT:      if (cnt_q == '0) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs decode straight from state; no input-to-output path.
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        data_out_d = data_out_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d = data;
                    cnt_d = shamt;
                    op_d  = sh_op_t'(op);
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - SHAMT_WIDTH'(1);
                end else begin
                    data_out_d = acc_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            op_q       <= SH_SLL;
            data_out_q <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            data_out_q <= data_out_d;
        end
    end

    assign dataOut = data_out_q;

endmodule
